sdrd_read_sequencer: RTL

- Bus-side controller that drives the 93xx serial-security PAL window.
- Per request: issues one clear cycle, then a programmed number of read cycles at a fixed address nibble, and shifts the returned SDRD bit from each cycle into a response word.
- Sits between the CPU-side register interface (valid/ready request and response) and the PAL's BA13/BA12/BA7-4, BR_W, SSER and clock pins.
- Paces the PAL with an explicit clock-enable strobe.

---
 rtl/sdrd_read_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sdrd_read_sequencer.sv
// Read sequencer for the 93xx serial-security PAL window.
// Issues a clear strobe, then N read strobes, shifting SDRD into rsp_data.
module sdrd_read_sequencer #(
    parameter int          NBITS = 8,
    parameter int          SETUP = 2,
    parameter logic [1:0]  WIN   = 2'b01,
    localparam int         LW    = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_nib,
    input  logic [LW-1:0]    req_len,
    input  logic             abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NBITS-1:0] rsp_data,
    output logic             rsp_aborted,
    output logic [1:0]       ba_hi,
    output logic [3:0]       ba_nib,
    output logic             br_w,
    output logic             sser_n,
    output logic             pal_clk,
    input  logic             sdrd
);

    typedef enum logic [2:0] {
        IDLE, CLR_SET, CLR_STB, RD_SET, RD_STB, RD_SMP, DONE
    } state_t;

    localparam logic [3:0]    SET_LD = 4'(SETUP - 1);
    localparam logic [LW-1:0] LEN_MX = LW'(NBITS);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [LW-1:0]      rem_q, rem_d;
    logic [3:0]         nib_q, nib_d;
    logic [NBITS-1:0]   data_q, data_d;
    logic               abrt_q, abrt_d;
    logic               take_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            nib_q   <= '0;
            data_q  <= '0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            nib_q   <= nib_d;
            data_q  <= data_d;
            abrt_q  <= abrt_d;
        end
    end

    // Once an abort is latched, further abort pulses are ignored so the
    // recovery clear phase always runs to completion.
    assign take_abort = abort & ~abrt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        nib_d     = nib_q;
        data_d    = data_q;
        abrt_d    = abrt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        ba_hi     = 2'b00;
        ba_nib    = 4'h0;
        br_w      = 1'b1;
        sser_n    = 1'b1;
        pal_clk   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nib_d   = req_nib;
                    rem_d   = (req_len > LEN_MX) ? LEN_MX : req_len;
                    data_d  = '0;
                    abrt_d  = 1'b0;
                    cnt_d   = SET_LD;
                    state_d = CLR_SET;
                end
            end
            CLR_SET: begin
                ba_hi  = WIN;
                br_w   = 1'b0;
                sser_n = 1'b0;
                if (take_abort) begin
                    abrt_d = 1'b1;
                    cnt_d  = SET_LD;
                end else if (cnt_q == 4'd0) begin
                    state_d = CLR_STB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CLR_STB: begin
                ba_hi   = WIN;
                br_w    = 1'b0;
                sser_n  = 1'b0;
                pal_clk = 1'b1;
                cnt_d   = SET_LD;
                if (take_abort) begin
                    abrt_d  = 1'b1;
                    state_d = CLR_SET;
                end else if (abrt_q || rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = RD_SET;
                end
            end
            RD_SET: begin
                ba_hi  = WIN;
                ba_nib = nib_q;
                sser_n = 1'b0;
                if (take_abort) begin
                    abrt_d  = 1'b1;
                    cnt_d   = SET_LD;
                    state_d = CLR_SET;
                end else if (cnt_q == 4'd0) begin
                    state_d = RD_STB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_STB: begin
                ba_hi   = WIN;
                ba_nib  = nib_q;
                sser_n  = 1'b0;
                pal_clk = 1'b1;
                cnt_d   = SET_LD;
                state_d = RD_SMP;
                if (take_abort) begin
                    abrt_d = 1'b1;
                end
            end
            RD_SMP: begin
                ba_hi  = WIN;
                ba_nib = nib_q;
                sser_n = 1'b0;
                if (take_abort) begin
                    abrt_d  = 1'b1;
                    cnt_d   = SET_LD;
                    state_d = CLR_SET;
                end else if (cnt_q == 4'd0) begin
                    data_d = {data_q[NBITS-2:0], sdrd};
                    rem_d  = rem_q - LW'(1);
                    cnt_d  = SET_LD;
                    if (abrt_q) begin
                        state_d = CLR_SET;
                    end else if (rem_q == LW'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_SET;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_data    = data_q;
    assign rsp_aborted = abrt_q;

endmodule
